// File: rtl/tuser_sequencer.sv
// tuser_sequencer: walks a (row, col, cin) image scan after a configuration
// handshake and emits one tuser beat per position. The first beat of each
// job carries the configuration; later beats carry the position flags that
// the pad filter and conv datapath consume. The output is a single
// registered slice, so beats go out back to back when the consumer is ready.
module tuser_sequencer #(
    parameter int KW_MAX    = 7,
    parameter int SW_MAX    = 4,
    parameter int BITS_COLS = 10,
    parameter int BITS_CIN  = 10,
    parameter int BITS_ROWS = 10,
    localparam int KW2_MAX  = KW_MAX / 2,
    localparam int BITS_KW2 = $clog2(KW2_MAX + 1),
    localparam int BITS_SW  = $clog2(SW_MAX)
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 aclken,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [BITS_KW2-1:0]  cfg_kw2,
    input  logic [BITS_SW-1:0]   cfg_sw_1,
    input  logic [BITS_COLS-1:0] cfg_cols_1,
    input  logic [BITS_CIN-1:0]  cfg_cin_1,
    input  logic [BITS_ROWS-1:0] cfg_rows_1,
    output logic                 cfg_error,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [BITS_KW2-1:0]  m_kw2,
    output logic [BITS_SW-1:0]   m_sw_1,
    output logic                 m_is_config,
    output logic                 m_is_cin_last,
    output logic                 m_is_col_1_k2,
    output logic                 m_is_col_valid,
    output logic                 m_last,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CFG  = 2'd1,
        RUN  = 2'd2
    } state_t;

    // A configuration is usable only if the kernel and stride fit the build
    // and the image is at least as wide as the kernel.
    function automatic logic cfg_legal(
        input logic [BITS_KW2-1:0]  kw2,
        input logic [BITS_SW-1:0]   sw_1,
        input logic [BITS_COLS-1:0] cols_1
    );
        if (int'(kw2) > KW2_MAX) begin
            cfg_legal = 1'b0;
        end else if (int'(sw_1) >= SW_MAX) begin
            cfg_legal = 1'b0;
        end else if (int'(cols_1) < 2 * int'(kw2)) begin
            cfg_legal = 1'b0;
        end else begin
            cfg_legal = 1'b1;
        end
    endfunction

    state_t                state_q, state_d;
    logic [BITS_KW2-1:0]   kw2_q, kw2_d;
    logic [BITS_SW-1:0]    sw_1_q, sw_1_d;
    logic [BITS_COLS-1:0]  cols_1_q, cols_1_d;
    logic [BITS_CIN-1:0]   cin_1_q, cin_1_d;
    logic [BITS_ROWS-1:0]  rows_1_q, rows_1_d;
    logic [BITS_CIN-1:0]   cin_cnt_q, cin_cnt_d;
    logic [BITS_COLS-1:0]  col_cnt_q, col_cnt_d;
    logic [BITS_ROWS-1:0]  row_cnt_q, row_cnt_d;
    logic [BITS_SW-1:0]    ph_q, ph_d;
    logic                  m_valid_q, m_valid_d;
    logic [BITS_KW2-1:0]   m_kw2_q, m_kw2_d;
    logic [BITS_SW-1:0]    m_sw_1_q, m_sw_1_d;
    logic                  m_is_config_q, m_is_config_d;
    logic                  m_is_cin_last_q, m_is_cin_last_d;
    logic                  m_is_col_1_k2_q, m_is_col_1_k2_d;
    logic                  m_is_col_valid_q, m_is_col_valid_d;
    logic                  m_last_q, m_last_d;
    logic                  cfg_error_q, cfg_error_d;
    logic                  cfg_ready_q, cfg_ready_d;
    logic                  busy_q, busy_d;

    // Flags of the beat at the current counter position, and the counter
    // values that follow it.
    logic                  cin_last_s, col_last_s, row_last_s;
    logic                  col_1_k2_s, col_valid_s, last_s;
    logic [BITS_CIN-1:0]   cin_adv_s;
    logic [BITS_COLS-1:0]  col_adv_s;
    logic [BITS_ROWS-1:0]  row_adv_s;
    logic [BITS_SW-1:0]    ph_adv_s;

    // Decode the beat at the counter position and compute the next position
    // (cin fastest, then col, then row; stride phase restarts every row).
    always_comb begin
        cin_last_s  = (cin_cnt_q == cin_1_q);
        col_last_s  = (col_cnt_q == cols_1_q);
        row_last_s  = (row_cnt_q == rows_1_q);
        col_1_k2_s  = (kw2_q != {BITS_KW2{1'b0}}) &&
                      (col_cnt_q == (cols_1_q - BITS_COLS'(kw2_q)));
        col_valid_s = (ph_q == {BITS_SW{1'b0}});
        last_s      = cin_last_s && col_last_s && row_last_s;
        cin_adv_s   = cin_cnt_q;
        col_adv_s   = col_cnt_q;
        row_adv_s   = row_cnt_q;
        ph_adv_s    = ph_q;
        if (cin_last_s) begin
            cin_adv_s = {BITS_CIN{1'b0}};
            if (col_last_s) begin
                col_adv_s = {BITS_COLS{1'b0}};
                ph_adv_s  = {BITS_SW{1'b0}};
                if (row_last_s) begin
                    row_adv_s = {BITS_ROWS{1'b0}};
                end else begin
                    row_adv_s = row_cnt_q + BITS_ROWS'(1'b1);
                end
            end else begin
                col_adv_s = col_cnt_q + BITS_COLS'(1'b1);
                if (ph_q == sw_1_q) begin
                    ph_adv_s = {BITS_SW{1'b0}};
                end else begin
                    ph_adv_s = ph_q + BITS_SW'(1'b1);
                end
            end
        end else begin
            cin_adv_s = cin_cnt_q + BITS_CIN'(1'b1);
        end
    end

    // FSM next state and output-slice loading; a new beat is loaded only
    // when the slice is empty or its current beat is being taken.
    always_comb begin
        state_d          = state_q;
        kw2_d            = kw2_q;
        sw_1_d           = sw_1_q;
        cols_1_d         = cols_1_q;
        cin_1_d          = cin_1_q;
        rows_1_d         = rows_1_q;
        cin_cnt_d        = cin_cnt_q;
        col_cnt_d        = col_cnt_q;
        row_cnt_d        = row_cnt_q;
        ph_d             = ph_q;
        m_valid_d        = m_valid_q;
        m_kw2_d          = m_kw2_q;
        m_sw_1_d         = m_sw_1_q;
        m_is_config_d    = m_is_config_q;
        m_is_cin_last_d  = m_is_cin_last_q;
        m_is_col_1_k2_d  = m_is_col_1_k2_q;
        m_is_col_valid_d = m_is_col_valid_q;
        m_last_d         = m_last_q;
        cfg_error_d      = 1'b0;
        cfg_ready_d      = cfg_ready_q;
        busy_d           = busy_q;

        case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    kw2_d    = cfg_kw2;
                    sw_1_d   = cfg_sw_1;
                    cols_1_d = cfg_cols_1;
                    cin_1_d  = cfg_cin_1;
                    rows_1_d = cfg_rows_1;
                    if (cfg_legal(cfg_kw2, cfg_sw_1, cfg_cols_1)) begin
                        state_d          = CFG;
                        cfg_ready_d      = 1'b0;
                        busy_d           = 1'b1;
                        cin_cnt_d        = {BITS_CIN{1'b0}};
                        col_cnt_d        = {BITS_COLS{1'b0}};
                        row_cnt_d        = {BITS_ROWS{1'b0}};
                        ph_d             = {BITS_SW{1'b0}};
                        m_valid_d        = 1'b1;
                        m_kw2_d          = cfg_kw2;
                        m_sw_1_d         = cfg_sw_1;
                        m_is_config_d    = 1'b1;
                        m_is_cin_last_d  = 1'b0;
                        m_is_col_1_k2_d  = 1'b0;
                        m_is_col_valid_d = 1'b0;
                        m_last_d         = 1'b0;
                    end else begin
                        cfg_error_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CFG, RUN: begin
                if (m_ready) begin
                    if ((state_q == RUN) && m_last_q) begin
                        // Final beat taken: the job is complete.
                        state_d     = IDLE;
                        m_valid_d   = 1'b0;
                        busy_d      = 1'b0;
                        cfg_ready_d = 1'b1;
                    end else begin
                        state_d          = RUN;
                        m_valid_d        = 1'b1;
                        m_kw2_d          = kw2_q;
                        m_sw_1_d         = sw_1_q;
                        m_is_config_d    = 1'b0;
                        m_is_cin_last_d  = cin_last_s;
                        m_is_col_1_k2_d  = col_1_k2_s;
                        m_is_col_valid_d = col_valid_s;
                        m_last_d         = last_s;
                        cin_cnt_d        = cin_adv_s;
                        col_cnt_d        = col_adv_s;
                        row_cnt_d        = row_adv_s;
                        ph_d             = ph_adv_s;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d     = IDLE;
                m_valid_d   = 1'b0;
                busy_d      = 1'b0;
                cfg_ready_d = 1'b1;
            end
        endcase
    end

    // State, configuration, counters and output slice; reset wins over the
    // clock enable, otherwise everything holds while aclken is low.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q          <= IDLE;
            kw2_q            <= {BITS_KW2{1'b0}};
            sw_1_q           <= {BITS_SW{1'b0}};
            cols_1_q         <= {BITS_COLS{1'b0}};
            cin_1_q          <= {BITS_CIN{1'b0}};
            rows_1_q         <= {BITS_ROWS{1'b0}};
            cin_cnt_q        <= {BITS_CIN{1'b0}};
            col_cnt_q        <= {BITS_COLS{1'b0}};
            row_cnt_q        <= {BITS_ROWS{1'b0}};
            ph_q             <= {BITS_SW{1'b0}};
            m_valid_q        <= 1'b0;
            m_kw2_q          <= {BITS_KW2{1'b0}};
            m_sw_1_q         <= {BITS_SW{1'b0}};
            m_is_config_q    <= 1'b0;
            m_is_cin_last_q  <= 1'b0;
            m_is_col_1_k2_q  <= 1'b0;
            m_is_col_valid_q <= 1'b0;
            m_last_q         <= 1'b0;
            cfg_error_q      <= 1'b0;
            cfg_ready_q      <= 1'b1;
            busy_q           <= 1'b0;
        end else if (aclken) begin
            state_q          <= state_d;
            kw2_q            <= kw2_d;
            sw_1_q           <= sw_1_d;
            cols_1_q         <= cols_1_d;
            cin_1_q          <= cin_1_d;
            rows_1_q         <= rows_1_d;
            cin_cnt_q        <= cin_cnt_d;
            col_cnt_q        <= col_cnt_d;
            row_cnt_q        <= row_cnt_d;
            ph_q             <= ph_d;
            m_valid_q        <= m_valid_d;
            m_kw2_q          <= m_kw2_d;
            m_sw_1_q         <= m_sw_1_d;
            m_is_config_q    <= m_is_config_d;
            m_is_cin_last_q  <= m_is_cin_last_d;
            m_is_col_1_k2_q  <= m_is_col_1_k2_d;
            m_is_col_valid_q <= m_is_col_valid_d;
            m_last_q         <= m_last_d;
            cfg_error_q      <= cfg_error_d;
            cfg_ready_q      <= cfg_ready_d;
            busy_q           <= busy_d;
        end
    end

    assign cfg_ready      = cfg_ready_q;
    assign cfg_error      = cfg_error_q;
    assign busy           = busy_q;
    assign m_valid        = m_valid_q;
    assign m_kw2          = m_kw2_q;
    assign m_sw_1         = m_sw_1_q;
    assign m_is_config    = m_is_config_q;
    assign m_is_cin_last  = m_is_cin_last_q;
    assign m_is_col_1_k2  = m_is_col_1_k2_q;
    assign m_is_col_valid = m_is_col_valid_q;
    assign m_last         = m_last_q;

endmodule

// File: tb/tb_tuser_sequencer.sv
// Directed bench for tuser_sequencer: configuration handshake, beat order and
// flags, stalls, rejected configurations, mid-run reset and clock gating.
// Built with KW_MAX=5 so that an over-range kernel is representable.
module tb_tuser_sequencer;

    localparam int KW_MAX = 5;
    localparam int BK     = 2;
    localparam int BS     = 2;

    logic          aclk = 1'b0;
    logic          areset;
    logic          aclken;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [BK-1:0] cfg_kw2;
    logic [BS-1:0] cfg_sw_1;
    logic [9:0]    cfg_cols_1;
    logic [9:0]    cfg_cin_1;
    logic [9:0]    cfg_rows_1;
    logic          cfg_error;
    logic          m_valid;
    logic          m_ready;
    logic [BK-1:0] m_kw2;
    logic [BS-1:0] m_sw_1;
    logic          m_is_config;
    logic          m_is_cin_last;
    logic          m_is_col_1_k2;
    logic          m_is_col_valid;
    logic          m_last;
    logic          busy;

    tuser_sequencer #(.KW_MAX(KW_MAX)) dut (
        .aclk           (aclk),
        .areset         (areset),
        .aclken         (aclken),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_kw2        (cfg_kw2),
        .cfg_sw_1       (cfg_sw_1),
        .cfg_cols_1     (cfg_cols_1),
        .cfg_cin_1      (cfg_cin_1),
        .cfg_rows_1     (cfg_rows_1),
        .cfg_error      (cfg_error),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_kw2          (m_kw2),
        .m_sw_1         (m_sw_1),
        .m_is_config    (m_is_config),
        .m_is_cin_last  (m_is_cin_last),
        .m_is_col_1_k2  (m_is_col_1_k2),
        .m_is_col_valid (m_is_col_valid),
        .m_last         (m_last),
        .busy           (busy)
    );

    // Free-running clock.
    always #5 aclk = ~aclk;

    int total = 0;
    int bad   = 0;

    // Accepted beats, packed {config, cin_last, col_1_k2, col_valid, last, kw2, sw_1}.
    logic [8:0] beats[$];
    int         beat_cyc[$];
    int         acc_cyc;
    logic [8:0] exp039[9];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] ovec();
        ovec = {m_valid, m_is_config, m_is_cin_last, m_is_col_1_k2,
                m_is_col_valid, m_last, m_kw2, m_sw_1};
    endfunction

    // Offer one configuration and collect beats until the last one is taken.
    // stall_at: beat count at which m_ready drops for 5 cycles (-1 = never).
    // abort_at: beat count at which areset is pulsed with aclken low (-1 = never).
    task automatic run(input logic [BK-1:0] kw2, input logic [BS-1:0] sw,
                       input logic [9:0] cols, input logic [9:0] cin,
                       input logic [9:0] rows, input int stall_at,
                       input int abort_at, input bit rnd, output bit ok);
        int         stall_left;
        bit         stalled;
        bit         acc;
        bit         fin;
        int         n;
        logic [9:0] snap;
        stall_left = 0;
        stalled    = 1'b0;
        acc        = 1'b0;
        fin        = 1'b0;
        n          = 0;
        snap       = 10'd0;
        ok         = 1'b0;
        beats.delete();
        beat_cyc.delete();
        cfg_valid  = 1'b1;
        cfg_kw2    = kw2;
        cfg_sw_1   = sw;
        cfg_cols_1 = cols;
        cfg_cin_1  = cin;
        cfg_rows_1 = rows;
        for (int c = 0; c < 400; c++) begin
            if (abort_at >= 0 && n == abort_at) begin
                aclken  = 1'b0;
                areset  = 1'b1;
                m_ready = 1'b1;
                @(posedge aclk);
                #1;
                areset = 1'b0;
                aclken = 1'b1;
                @(negedge aclk);
                chk("rst_m_valid", 32'(m_valid), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
                @(posedge aclk);
                #1;
                ok = 1'b1;
                break;
            end
            aclken = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (acc) cfg_valid = 1'b0;
            if (stall_at >= 0 && !stalled && n == stall_at) begin
                stalled    = 1'b1;
                stall_left = 5;
            end
            m_ready = (stall_left > 0) ? 1'b0 : 1'b1;
            @(negedge aclk);
            if (stall_left == 5) begin
                snap = ovec();
                chk("stall_valid", 32'(m_valid), 32'd1);
            end else if (stall_left > 0) begin
                chk("stall_hold", 32'(ovec()), 32'(snap));
            end
            if (!acc && cfg_valid && cfg_ready && aclken) begin
                acc     = 1'b1;
                acc_cyc = c;
            end
            if (m_valid && m_ready && aclken) begin
                beats.push_back({m_is_config, m_is_cin_last, m_is_col_1_k2,
                                 m_is_col_valid, m_last, m_kw2, m_sw_1});
                beat_cyc.push_back(c);
                n++;
                if (m_last) fin = 1'b1;
            end
            @(posedge aclk);
            #1;
            if (stall_left > 0) stall_left--;
            if (fin) begin
                ok = 1'b1;
                break;
            end
        end
        cfg_valid = 1'b0;
        aclken    = 1'b1;
        m_ready   = 1'b1;
        chk("run_complete", 32'(ok), 32'd1);
    endtask

    task automatic check_039(input string tag);
        chk({tag, "_count"}, 32'(beats.size()), 32'd9);
        for (int i = 0; i < 9; i++) begin
            if (i < beats.size()) chk($sformatf("%s_beat%0d", tag, i), 32'(beats[i]), 32'(exp039[i]));
        end
    endtask

    // Present one illegal configuration for a single cycle and watch a few cycles.
    task automatic bad_cfg(input string tag, input logic [BK-1:0] kw2, input logic [9:0] cols);
        int pulses;
        int vseen;
        int bseen;
        pulses     = 0;
        vseen      = 0;
        bseen      = 0;
        aclken     = 1'b1;
        m_ready    = 1'b1;
        cfg_valid  = 1'b1;
        cfg_kw2    = kw2;
        cfg_sw_1   = 2'd0;
        cfg_cols_1 = cols;
        cfg_cin_1  = 10'd0;
        cfg_rows_1 = 10'd0;
        for (int c = 0; c < 6; c++) begin
            @(negedge aclk);
            if (cfg_error) pulses++;
            if (m_valid) vseen++;
            if (busy) bseen++;
            @(posedge aclk);
            #1;
            cfg_valid = 1'b0;
        end
        chk({tag, "_err_pulses"}, 32'(pulses), 32'd1);
        chk({tag, "_no_beats"}, 32'(vseen), 32'd0);
        chk({tag, "_busy"}, 32'(bseen), 32'd0);
    endtask

    initial begin
        bit         ok;
        logic [6:0] cvpat;
        logic [8:0] e;
        int         col;

        exp039[0] = 9'b10000_0100;
        exp039[1] = 9'b00010_0100;
        exp039[2] = 9'b01010_0100;
        exp039[3] = 9'b00010_0100;
        exp039[4] = 9'b01010_0100;
        exp039[5] = 9'b00110_0100;
        exp039[6] = 9'b01110_0100;
        exp039[7] = 9'b00010_0100;
        exp039[8] = 9'b01011_0100;

        areset     = 1'b1;
        aclken     = 1'b1;
        cfg_valid  = 1'b0;
        cfg_kw2    = 2'd0;
        cfg_sw_1   = 2'd0;
        cfg_cols_1 = 10'd0;
        cfg_cin_1  = 10'd0;
        cfg_rows_1 = 10'd0;
        m_ready    = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        areset = 1'b0;
        @(negedge aclk);
        chk("reset_cfg_ready", 32'(cfg_ready), 32'd1);
        chk("reset_outputs", 32'(ovec()), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_cfg_error", 32'(cfg_error), 32'd0);
        @(posedge aclk);
        #1;

        // Basic sequence with m_ready held high.
        run(2'd1, 2'd0, 10'd3, 10'd1, 10'd0, -1, -1, 1'b0, ok);
        check_039("t039");
        if (beat_cyc.size() == 9) begin
            chk("t039_first_latency", 32'(beat_cyc[0] - acc_cyc), 32'd1);
            chk("t039_no_bubbles", 32'(beat_cyc[8] - beat_cyc[0]), 32'd8);
        end else begin
            chk("t039_beat_times", 32'(beat_cyc.size()), 32'd9);
        end
        @(negedge aclk);
        chk("t039_busy_after", 32'(busy), 32'd0);
        chk("t039_valid_after", 32'(m_valid), 32'd0);
        chk("t039_ready_after", 32'(cfg_ready), 32'd1);
        @(posedge aclk);
        #1;

        // Stride 2, kernel 5, two rows, single channel.
        run(2'd2, 2'd1, 10'd6, 10'd0, 10'd1, -1, -1, 1'b0, ok);
        chk("t040_count", 32'(beats.size()), 32'd15);
        cvpat = 7'b1010101;
        for (int i = 0; i < 15; i++) begin
            if (i == 0) begin
                e = 9'b10000_1001;
            end else begin
                col = (i - 1) % 7;
                e = {1'b0, 1'b1, (col == 4), cvpat[col], (i == 14), 2'd2, 2'd1};
            end
            if (i < beats.size()) chk($sformatf("t040_beat%0d", i), 32'(beats[i]), 32'(e));
        end

        // Five-cycle stall in the middle of the run.
        run(2'd1, 2'd0, 10'd3, 10'd1, 10'd0, 4, -1, 1'b0, ok);
        check_039("t041");

        // Rejected configurations: kernel too large, then image too narrow.
        bad_cfg("t042a", 2'd3, 10'd9);
        bad_cfg("t042b", 2'd1, 10'd1);

        // Reset while RUN beat 3 is pending, then start over.
        run(2'd1, 2'd0, 10'd3, 10'd1, 10'd0, -1, 3, 1'b0, ok);
        run(2'd1, 2'd0, 10'd3, 10'd1, 10'd0, -1, -1, 1'b0, ok);
        check_039("t043");

        // Random clock-enable gating.
        run(2'd1, 2'd0, 10'd3, 10'd1, 10'd0, -1, -1, 1'b1, ok);
        check_039("t044");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tuser_sequencer.md
TUSER_SEQUENCER -- requirements
Module: tuser_sequencer

Interface
REQ-001: Parameter KW_MAX, default 7, is the largest odd kernel width supported; KW2_MAX = KW_MAX/2.
REQ-002: Parameter SW_MAX, default 4, is the largest horizontal stride supported.
REQ-003: Parameters BITS_COLS, BITS_CIN and BITS_ROWS, each default 10, set the counter widths; BITS_KW2 = clog2(KW2_MAX+1) and BITS_SW = clog2(SW_MAX).
REQ-004: aclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005: areset, input, 1 bit: reset is synchronous and active-high.
REQ-006: aclken, input, 1 bit: clock enable; when low, all state holds.
REQ-007: cfg_valid/cfg_ready, input/output, 1 bit each: configuration handshake.
REQ-008: cfg_kw2, input, BITS_KW2 bits: kernel width kw = 2*cfg_kw2+1.
REQ-009: cfg_sw_1, input, BITS_SW bits: stride minus one.
REQ-010: cfg_cols_1, cfg_cin_1 and cfg_rows_1, inputs of BITS_COLS, BITS_CIN and BITS_ROWS bits: image columns, input channels and rows, each minus one.
REQ-011: cfg_error, output, 1 bit: one-cycle pulse when a configuration is rejected.
REQ-012: m_valid/m_ready, output/input, 1 bit each: tuser stream handshake.
REQ-013: m_kw2 (BITS_KW2), m_sw_1 (BITS_SW), m_is_config, m_is_cin_last, m_is_col_1_k2, m_is_col_valid, m_last: outputs forming the tuser beat consumed by the pad filter and conv datapath.
REQ-014: busy, output, 1 bit: high from configuration acceptance until the final beat is accepted.

Function
REQ-015: The FSM shall have three states: IDLE, CFG and RUN.
REQ-016: IDLE: cfg_ready=1; on cfg_valid&&aclken, latch all cfg_* fields; go to CFG if the configuration is legal, else pulse cfg_error and stay in IDLE.
REQ-017: A configuration is illegal if cfg_kw2>KW2_MAX, cfg_sw_1>=SW_MAX, or cfg_cols_1<2*cfg_kw2.
REQ-018: CFG shall emit exactly one beat with m_is_config=1, latched kw2/sw_1, and all other flags 0; on acceptance, clear all counters and go to RUN.
REQ-019: In RUN, beat order shall be cin fastest, then col, then row; one beat per (row, col, cin).
REQ-020: Counters cin_cnt, col_cnt and row_cnt shall advance only on output acceptance (m_valid&&m_ready&&aclken), as shall stride phase ph (0..sw_1, wrapping).
REQ-021: ph shall increment when a column completes (cin_cnt==cin_1) and reset to 0 at each row start.
REQ-022: m_is_cin_last = (cin_cnt==cin_1).
REQ-023: m_is_col_1_k2 = (kw2!=0) && (col_cnt==cols_1-kw2), asserted on every cin beat of that column.
REQ-024: m_is_col_valid = (ph==0).
REQ-025: m_last = 1 on the beat where cin, col and row counters are all terminal; its acceptance returns the FSM to IDLE and drops busy.
REQ-026: All RUN beats shall carry the latched kw2 and sw_1.
REQ-027: The output shall be a registered slice; its next beat loads when !m_valid || m_ready.
REQ-028: Accepted configuration to first m_valid shall take 1 cycle; with m_ready held high, throughput shall be one beat per cycle with no bubbles, including across the CFG->RUN transition.
REQ-029: When m_ready is low, the m_* outputs shall hold stable and the counters shall not advance.
REQ-030: When aclken is low, no state, counter or output shall change, and cfg_error shall not pulse.
REQ-031: cfg_ready shall be 0 outside IDLE; cfg_valid outside IDLE is ignored and not latched.
REQ-032: When cin_1=0, every beat shall have m_is_cin_last=1.
REQ-033: When kw2=0, m_is_col_1_k2 shall never assert.
REQ-034: When sw_1=0, every RUN beat shall have m_is_col_valid=1.
REQ-035: Counter wrap shall occur only at the programmed terminal value; there is no overflow for legal configurations.

Reset
REQ-036: While areset is high at an enabled or disabled edge, the FSM shall go to IDLE and m_valid, busy and cfg_error shall be 0.
REQ-037: Reset shall zero all counters, the latched configuration and all m_* flags; cfg_ready shall be 1 in the first cycle after reset.
REQ-038: Reset mid-RUN shall discard the pending beat without completing it; the next configuration restarts from the config beat.

Verification
REQ-039: Configure kw2=1, sw_1=0, cols_1=3, cin_1=1, rows_1=0 with m_ready=1 -> 9 consecutive beats: config beat, then 8 beats; is_cin_last on RUN beats 2,4,6,8; is_col_1_k2 on beats 5,6; last on beat 8 only; busy low the cycle after.
REQ-040: Configure kw2=2, sw_1=1, cols_1=6, cin_1=0, rows_1=1 -> is_col_valid pattern 1,0,1,0,1,0,1 per row, restarting at row 2; is_col_1_k2 at col 4 each row.
REQ-041: Hold m_ready=0 for 5 cycles mid-RUN -> all m_* outputs stable and the beat count unchanged (8 RUN beats plus 1 config beat in the REQ-039 case).
REQ-042: Apply cfg_kw2=KW2_MAX+1, then cfg_cols_1=1 with kw2=1 -> cfg_error pulses once each, busy stays 0 and no beats are emitted.
REQ-043: Assert areset at RUN beat 3, then reconfigure -> m_valid=0 the next cycle, and the new sequence begins with m_is_config=1.
REQ-044: Toggle aclken randomly during the REQ-039 configuration -> beat sequence identical to REQ-039.
